id_stage_bypass: RTL and testbench

//  Parametrised MIPS decode stage: pipeline register + valid/allowin handshake between IF and EX.

---
 rtl/id_stage_bypass_pkg.sv | 50 +++++
 rtl/id_fwd_mux.sv | 34 +++
 rtl/id_stage_bypass.sv | 171 +++++++++++++++++
 tb/tb_id_stage_bypass.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_bypass_pkg.sv
// Shared decode constants for the ID stage: ALU one-hot bit indices, MIPS opcode/funct codes
// and the 6-to-64 one-hot decoder reused for the opcode and funct fields.
package id_stage_bypass_pkg;

  localparam int unsigned AluOpWd = 12;
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluSll  = 4;
  localparam int unsigned AluSrl  = 5;
  localparam int unsigned AluSra  = 6;
  localparam int unsigned AluLui  = 7;
  localparam int unsigned AluAnd  = 8;
  localparam int unsigned AluOr   = 9;
  localparam int unsigned AluXor  = 10;
  localparam int unsigned AluNor  = 11;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0a;
  localparam logic [5:0] OpSltiu   = 6'h0b;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  function automatic logic [63:0] decoder_6_64(input logic [5:0] in);
    decoder_6_64 = 64'd1 << in;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand bypass select: the lowest-index matching forward source wins, else RF data.
// Register $0 always reads zero and never reports a pending (not-ready) producer.
module id_fwd_mux #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 3
) (
  input  logic [4:0]           addr,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [5*NFWD-1:0]    fwd_waddr,
  input  logic [XLEN*NFWD-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_ready,
  output logic [XLEN-1:0]      val,
  output logic                 hit_not_ready
);

  always_comb begin
    val           = rf_data;
    hit_not_ready = 1'b0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_we[i] && (fwd_waddr[5*i +: 5] == addr)) begin
        val           = fwd_wdata[XLEN*i +: XLEN];
        hit_not_ready = ~fwd_ready[i];
      end
    end
    if (addr == 5'd0) begin
      val           = '0;
      hit_not_ready = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage_bypass.sv
// MIPS decode stage with valid/allowin handshake, prioritised operand bypass, load-use stall
// and in-ID branch resolution. Define ID_IMM_LOGIC_EN to decode andi/ori/xori/slti/sltiu.
module id_stage_bypass
  import id_stage_bypass_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  es_allowin,
  output logic                  ds_allowin,
  input  logic                  fs_to_ds_valid,
  input  logic [2*XLEN-1:0]     fs_to_ds_bus,
  output logic [XLEN:0]         br_bus,
  output logic                  ds_to_es_valid,
  output logic [41+3*XLEN-1:0]  ds_to_es_bus,
  output logic [4:0]            rs_addr,
  output logic [4:0]            rt_addr,
  input  logic [XLEN-1:0]       rs_data,
  input  logic [XLEN-1:0]       rt_data,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD-1:0]       fwd_we,
  input  logic [5*NFWD-1:0]     fwd_waddr,
  input  logic [XLEN*NFWD-1:0]  fwd_wdata,
  input  logic [NFWD-1:0]       fwd_ready
);

`ifdef ID_IMM_LOGIC_EN
  localparam bit ImmLogicEn = 1'b1;
`else
  localparam bit ImmLogicEn = 1'b0;
`endif

  logic              ds_valid_q;
  logic [2*XLEN-1:0] fs_bus_q;
  logic              ds_ready_go;

  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_q & ds_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      fs_bus_q   <= '0;
    end else if (ds_allowin) begin
      ds_valid_q <= fs_to_ds_valid;
      if (fs_to_ds_valid) fs_bus_q <= fs_to_ds_bus;
    end
  end

  logic [XLEN-1:0] pc;
  logic [31:0]     inst;
  logic [4:0]      rd;
  logic [15:0]     imm;
  logic [63:0]     op_d;
  logic [63:0]     fn_d;

  assign pc      = fs_bus_q[2*XLEN-1:XLEN];
  assign inst    = fs_bus_q[31:0];
  assign rs_addr = inst[25:21];
  assign rt_addr = inst[20:16];
  assign rd      = inst[15:11];
  assign imm     = inst[15:0];
  assign op_d    = decoder_6_64(inst[31:26]);
  assign fn_d    = decoder_6_64(inst[5:0]);

  logic special;
  logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_sll, inst_srl, inst_sra;
  logic inst_and, inst_or, inst_xor, inst_nor, inst_jr;
  logic inst_addiu, inst_lw, inst_sw, inst_lui, inst_beq, inst_bne, inst_jal;
  logic inst_andi, inst_ori, inst_xori, inst_slti, inst_sltiu, op_imm_any;

  assign special    = op_d[OpSpecial];
  assign inst_addu  = special & fn_d[FnAddu];
  assign inst_subu  = special & fn_d[FnSubu];
  assign inst_slt   = special & fn_d[FnSlt];
  assign inst_sltu  = special & fn_d[FnSltu];
  assign inst_sll   = special & fn_d[FnSll];
  assign inst_srl   = special & fn_d[FnSrl];
  assign inst_sra   = special & fn_d[FnSra];
  assign inst_and   = special & fn_d[FnAnd];
  assign inst_or    = special & fn_d[FnOr];
  assign inst_xor   = special & fn_d[FnXor];
  assign inst_nor   = special & fn_d[FnNor];
  assign inst_jr    = special & fn_d[FnJr];
  assign inst_addiu = op_d[OpAddiu];
  assign inst_lw    = op_d[OpLw];
  assign inst_sw    = op_d[OpSw];
  assign inst_lui   = op_d[OpLui];
  assign inst_beq   = op_d[OpBeq];
  assign inst_bne   = op_d[OpBne];
  assign inst_jal   = op_d[OpJal];
  assign inst_andi  = ImmLogicEn & op_d[OpAndi];
  assign inst_ori   = ImmLogicEn & op_d[OpOri];
  assign inst_xori  = ImmLogicEn & op_d[OpXori];
  assign inst_slti  = ImmLogicEn & op_d[OpSlti];
  assign inst_sltiu = ImmLogicEn & op_d[OpSltiu];
  // Immediate ops never read rt, even when they decode as NOP.
  assign op_imm_any = op_d[OpAndi] | op_d[OpOri] | op_d[OpXori] | op_d[OpSlti] | op_d[OpSltiu];

  logic [AluOpWd-1:0] alu_op;
  assign alu_op[AluAdd]  = inst_addu | inst_addiu | inst_lw | inst_sw;
  assign alu_op[AluSub]  = inst_subu;
  assign alu_op[AluSlt]  = inst_slt | inst_slti;
  assign alu_op[AluSltu] = inst_sltu | inst_sltiu;
  assign alu_op[AluSll]  = inst_sll;
  assign alu_op[AluSrl]  = inst_srl;
  assign alu_op[AluSra]  = inst_sra;
  assign alu_op[AluLui]  = inst_lui;
  assign alu_op[AluAnd]  = inst_and | inst_andi;
  assign alu_op[AluOr]   = inst_or | inst_ori;
  assign alu_op[AluXor]  = inst_xor | inst_xori;
  assign alu_op[AluNor]  = inst_nor;

  logic src1_is_sa, src1_is_pc, src2_is_imm, src2_is_uimm, src2_is_8;
  logic dst_is_rt, rf_we, rs_used, rt_used;
  logic [4:0] rf_waddr;

  assign src1_is_sa   = inst_sll | inst_srl | inst_sra;
  assign src1_is_pc   = inst_jal;
  assign src2_is_imm  = inst_addiu | inst_lui | inst_lw | inst_sw | inst_slti | inst_sltiu;
  assign src2_is_uimm = inst_andi | inst_ori | inst_xori;
  assign src2_is_8    = inst_jal;
  assign dst_is_rt    = inst_addiu | inst_lui | inst_lw | src2_is_uimm | inst_slti | inst_sltiu;
  assign rf_waddr     = inst_jal ? 5'd31 : (dst_is_rt ? rt_addr : rd);
  assign rf_we        = ds_valid_q & ((|alu_op & ~inst_sw) | inst_jal);
  assign rs_used      = ~(src1_is_sa | inst_lui | inst_jal);
  assign rt_used      = ~(inst_addiu | inst_lw | inst_lui | inst_jal | inst_jr | op_imm_any);

  logic [XLEN-1:0] rs_val, rt_val;
  logic            rs_hnr, rt_hnr;

  id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_rs_mux (
    .addr(rs_addr), .rf_data(rs_data), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_ready(fwd_ready),
    .val(rs_val), .hit_not_ready(rs_hnr)
  );

  id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_rt_mux (
    .addr(rt_addr), .rf_data(rt_data), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_ready(fwd_ready),
    .val(rt_val), .hit_not_ready(rt_hnr)
  );

  assign ds_ready_go = ~((rs_used & rs_hnr) | (rt_used & rt_hnr));

  logic [XLEN-1:0] pc_plus4, br_offs, br_target;
  logic            br_taken;

  assign pc_plus4 = pc + XLEN'(4);
  assign br_offs  = {{(XLEN-18){imm[15]}}, imm, 2'b00};

  always_comb begin
    br_target = '0;
    if (inst_beq | inst_bne) br_target = pc_plus4 + br_offs;
    else if (inst_jal)       br_target = {pc_plus4[XLEN-1:28], inst[25:0], 2'b00};
    else if (inst_jr)        br_target = rs_val;
  end

  assign br_taken = ds_valid_q & ds_ready_go & ((inst_beq & (rs_val == rt_val)) |
                    (inst_bne & (rs_val != rt_val)) | inst_jal | inst_jr);
  assign br_bus   = {br_taken, br_target};

  assign ds_to_es_bus = {alu_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_uimm, src2_is_8,
                         inst_lw, inst_sw, rf_we, rf_waddr, imm, rs_val, rt_val, pc};

  logic unused_dec;
  assign unused_dec = ^{op_d, fn_d};

endmodule

// File: tb/tb_id_stage_bypass.sv
// Randomised scoreboard bench for id_stage_bypass against a mnemonic-level reference model.
module tb_id_stage_bypass;
  localparam int XLEN = 32;
  localparam int NFWD = 3;
  localparam int BUSW = 41 + 3 * XLEN;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 es_allowin = 1'b0;
  logic                 ds_allowin;
  logic                 fs_to_ds_valid = 1'b0;
  logic [2*XLEN-1:0]    fs_to_ds_bus = '0;
  logic [XLEN:0]        br_bus;
  logic                 ds_to_es_valid;
  logic [BUSW-1:0]      ds_to_es_bus;
  logic [4:0]           rs_addr, rt_addr;
  logic [XLEN-1:0]      rs_data, rt_data;
  logic [NFWD-1:0]      fwd_valid = '0, fwd_we = '0, fwd_ready = '0;
  logic [5*NFWD-1:0]    fwd_waddr = '0;
  logic [XLEN*NFWD-1:0] fwd_wdata = '0;

  logic [NFWD-1:0]      nf_valid, nf_we, nf_ready;
  logic [5*NFWD-1:0]    nf_waddr;
  logic [XLEN*NFWD-1:0] nf_wdata;

  logic [31:0] rf [32];
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  always #5 clk = ~clk;

  id_stage_bypass #(.XLEN(XLEN), .NFWD(NFWD)) dut (
    .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .br_bus(br_bus),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_ready(fwd_ready)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [BUSW-1:0] bus;
    logic [XLEN:0]   br;
  } exp_t;
  exp_t exp_q[$];
  bit   allow_q[$];

  typedef struct packed {
    int       alu;
    bit       sa, pcs, imm, uimm, is8, ld, st, wr;
    logic [4:0] dest;
    bit       rs_used, rt_used;
    int       kind;  // 0 none, 1 beq, 2 bne, 3 jal, 4 jr
  } ctrl_t;

  bit          m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;

  function automatic ctrl_t decode(input logic [31:0] in);
    ctrl_t c;
    c = '0;
    c.alu = -1;
    c.rs_used = 1'b1;
    c.rt_used = 1'b1;
    c.dest = in[15:11];
    case (in[31:26])
      6'h00: case (in[5:0])
        6'h21: begin c.alu = 0;  c.wr = 1'b1; end
        6'h23: begin c.alu = 1;  c.wr = 1'b1; end
        6'h2a: begin c.alu = 2;  c.wr = 1'b1; end
        6'h2b: begin c.alu = 3;  c.wr = 1'b1; end
        6'h00: begin c.alu = 4;  c.wr = 1'b1; c.sa = 1'b1; c.rs_used = 1'b0; end
        6'h02: begin c.alu = 5;  c.wr = 1'b1; c.sa = 1'b1; c.rs_used = 1'b0; end
        6'h03: begin c.alu = 6;  c.wr = 1'b1; c.sa = 1'b1; c.rs_used = 1'b0; end
        6'h24: begin c.alu = 8;  c.wr = 1'b1; end
        6'h25: begin c.alu = 9;  c.wr = 1'b1; end
        6'h26: begin c.alu = 10; c.wr = 1'b1; end
        6'h27: begin c.alu = 11; c.wr = 1'b1; end
        6'h08: begin c.kind = 4; c.rt_used = 1'b0; end
        default: ;
      endcase
      6'h09: begin c.alu = 0; c.imm = 1'b1; c.wr = 1'b1; c.dest = in[20:16]; c.rt_used = 1'b0; end
      6'h23: begin
        c.alu = 0; c.imm = 1'b1; c.ld = 1'b1; c.wr = 1'b1; c.dest = in[20:16]; c.rt_used = 1'b0;
      end
      6'h2b: begin c.alu = 0; c.imm = 1'b1; c.st = 1'b1; end
      6'h0f: begin
        c.alu = 7; c.imm = 1'b1; c.wr = 1'b1; c.dest = in[20:16];
        c.rs_used = 1'b0; c.rt_used = 1'b0;
      end
      6'h04: c.kind = 1;
      6'h05: c.kind = 2;
      6'h03: begin
        c.kind = 3; c.pcs = 1'b1; c.is8 = 1'b1; c.wr = 1'b1; c.dest = 5'd31;
        c.rs_used = 1'b0; c.rt_used = 1'b0;
      end
      6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b: begin
        c.rt_used = 1'b0;
`ifdef ID_IMM_LOGIC_EN
        c.wr = 1'b1;
        c.dest = in[20:16];
        case (in[31:26])
          6'h0c:   begin c.alu = 8;  c.uimm = 1'b1; end
          6'h0d:   begin c.alu = 9;  c.uimm = 1'b1; end
          6'h0e:   begin c.alu = 10; c.uimm = 1'b1; end
          6'h0a:   begin c.alu = 2;  c.imm = 1'b1; end
          default: begin c.alu = 3;  c.imm = 1'b1; end
        endcase
`endif
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic void operand(input logic [4:0] a, output logic [31:0] v, output bit nr);
    v = rf[a];
    nr = 1'b0;
    if (a == 5'd0) begin
      v = '0;
      return;
    end
    for (int i = 0; i < NFWD; i++) begin
      if (fwd_valid[i] && fwd_we[i] && fwd_waddr[5*i +: 5] == a) begin
        v = fwd_wdata[32*i +: 32];
        nr = !fwd_ready[i];
        return;
      end
    end
  endfunction

  task automatic model_cycle();
    ctrl_t       c;
    logic [31:0] rv, tv, tgt;
    logic [11:0] a1;
    bit          rnr, tnr, go, taken, allow;
    exp_t        e;
    if (reset) begin
      allow_q.push_back(1'b1);
      m_valid = 1'b0;
      m_pc = '0;
      m_inst = '0;
      return;
    end
    c = decode(m_inst);
    operand(m_inst[25:21], rv, rnr);
    operand(m_inst[20:16], tv, tnr);
    go = !((c.rs_used && rnr) || (c.rt_used && tnr));
    allow = !m_valid || (go && es_allowin);
    allow_q.push_back(allow);
    if (m_valid && go) begin
      taken = (c.kind == 1 && rv == tv) || (c.kind == 2 && rv != tv) || c.kind == 3 || c.kind == 4;
      case (c.kind)
        1, 2:    tgt = m_pc + 32'd4 + (32'($signed(m_inst[15:0])) << 2);
        3:       tgt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'b0, m_inst[25:0], 2'b00};
        4:       tgt = rv;
        default: tgt = '0;
      endcase
      a1 = (c.alu >= 0) ? (12'd1 << c.alu) : 12'd0;
      e.br = {taken, tgt};
      e.bus = {a1, c.sa, c.pcs, c.imm, c.uimm, c.is8, c.ld, c.st, c.wr, c.dest,
               m_inst[15:0], rv, tv, m_pc};
      exp_q.push_back(e);
    end
    if (allow) begin
      m_valid = fs_to_ds_valid;
      if (fs_to_ds_valid) {m_pc, m_inst} = fs_to_ds_bus;
    end
  endtask

  task automatic step(input bit fv, input logic [31:0] pc, input logic [31:0] inst,
                      input bit ea, input bit rst);
    @(negedge clk);
    reset = rst;
    fs_to_ds_valid = fv;
    fs_to_ds_bus = {pc, inst};
    es_allowin = ea;
    fwd_valid = nf_valid;
    fwd_we = nf_we;
    fwd_waddr = nf_waddr;
    fwd_wdata = nf_wdata;
    fwd_ready = nf_ready;
    #1;
    model_cycle();
  endtask

  task automatic clear_fwd();
    nf_valid = '0; nf_we = '0; nf_ready = '0; nf_waddr = '0; nf_wdata = '0;
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d, input bit rdy);
    nf_valid[i] = 1'b1;
    nf_we[i] = 1'b1;
    nf_waddr[5*i +: 5] = a;
    nf_wdata[32*i +: 32] = d;
    nf_ready[i] = rdy;
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] s, t, d, sa, input logic [5:0] fn);
    return {6'h00, s, t, d, sa, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] s, t,
                                       input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  s = 5'($urandom_range(0, 7));
    logic [4:0]  t = 5'($urandom_range(0, 7));
    logic [4:0]  d = 5'($urandom_range(0, 7));
    logic [15:0] im = 16'($urandom);
    logic [5:0]  rfn [11];
    logic [5:0]  iop [10];
    int          k = $urandom_range(0, 21);
    rfn = '{6'h21, 6'h23, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h24, 6'h25, 6'h26, 6'h27};
    iop = '{6'h09, 6'h23, 6'h2b, 6'h0f, 6'h04, 6'h05, 6'h0c, 6'h0d, 6'h0e, 6'h0a};
    if (k < 11) return r_op(s, t, d, im[10:6], rfn[k]);
    if (k == 11) return r_op(s, 5'd0, 5'd0, 5'd0, 6'h08);
    if (k == 12) return {6'h03, 26'($urandom)};
    if (k == 21) return i_op(6'h0b, s, t, im);
    return i_op(iop[k-13], s, t, im);
  endfunction

  // Monitor: pops the scoreboard whenever ID presents a valid instruction.
  initial begin
    exp_t e;
    bit   ea;
    forever begin
      @(negedge clk);
      #3;
      if (allow_q.size() > 0) begin
        ea = allow_q.pop_front();
        total++;
        if (ds_allowin !== ea) begin
          bad++;
          $display("FAIL allowin t=%0t: got %b want %b", $time, ds_allowin, ea);
        end
      end
      if (ds_to_es_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_issue t=%0t: got valid=1 want valid=0", $time);
        end else begin
          e = exp_q.pop_front();
          if (ds_to_es_bus !== e.bus) begin
            bad++;
            $display("FAIL ds_bus t=%0t: got %h want %h", $time, ds_to_es_bus, e.bus);
          end
          total++;
          if (br_bus !== e.br) begin
            bad++;
            $display("FAIL br_bus t=%0t: got %h want %h", $time, br_bus, e.br);
          end
        end
      end else begin
        if (exp_q.size() > 0) begin
          total++;
          bad++;
          $display("FAIL missing_issue t=%0t: got valid=%b want valid=1", $time, ds_to_es_valid);
          void'(exp_q.pop_front());
        end
        total++;
        if (br_bus[XLEN] !== 1'b0) begin
          bad++;
          $display("FAIL br_taken_idle t=%0t: got %b want 0", $time, br_bus[XLEN]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    clear_fwd();
    #1 reset = 1'b1;
    #5;
    total += 3;
    if (ds_to_es_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ds_to_es_valid); end
    if (br_bus !== '0) begin bad++; $display("FAIL rst_br: got %h want 0", br_bus); end
    if (ds_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin: got %b want 1", ds_allowin); end

    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    // addu r3,r1,r2 from the RF
    step(1, 32'h100, r_op(1, 2, 3, 0, 6'h21), 1, 0);
    step(0, 0, 0, 1, 0);
    // addu r4,r3,r3: EX beats MEM
    set_src(0, 3, 32'd9, 1);
    set_src(1, 3, 32'd2, 1);
    step(1, 32'h104, r_op(3, 3, 4, 0, 6'h21), 1, 0);
    step(0, 0, 0, 1, 0);
    clear_fwd();
    // load-use: lw r5 in EX, then MEM supplies r5
    set_src(0, 5, 32'hdead, 0);
    step(1, 32'h108, r_op(5, 0, 6, 0, 6'h21), 1, 0);
    step(0, 0, 0, 1, 0);
    clear_fwd();
    set_src(1, 5, 32'h1234, 1);
    step(0, 0, 0, 1, 0);
    clear_fwd();
    // beq r1,r2,+3 taken then not taken via WB bypass
    set_src(2, 1, 32'd7, 1);
    step(1, 32'h100, i_op(6'h04, 1, 2, 16'd3), 1, 0);
    step(0, 0, 0, 1, 0);
    set_src(2, 1, 32'd8, 1);
    step(1, 32'h100, i_op(6'h04, 1, 2, 16'd3), 1, 0);
    step(0, 0, 0, 1, 0);
    clear_fwd();
    // $0 never bypasses
    for (int i = 0; i < NFWD; i++) set_src(i, 0, 32'hFFFF, 0);
    step(1, 32'h10c, r_op(0, 0, 1, 0, 6'h21), 1, 0);
    step(0, 0, 0, 1, 0);
    clear_fwd();
    // EX back-pressure, then reset while held
    step(1, 32'h200, r_op(1, 2, 7, 0, 6'h21), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    // ori r2,r1,0x8000 and a jal
    step(1, 32'h300, i_op(6'h0d, 1, 2, 16'h8000), 1, 0);
    step(1, 32'h1234_5678, {6'h03, 26'h2AB_CDEF}, 1, 0);
    step(0, 0, 0, 1, 0);

    for (int n = 0; n < 2000; n++) begin
      clear_fwd();
      for (int i = 0; i < NFWD; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_src(i, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
        nf_we[i] = nf_we[i] & ($urandom_range(0, 5) != 0);
      end
      step($urandom_range(0, 9) < 7, {$urandom} & 32'hFFFF_FFFC, rand_inst(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0);
    end

    clear_fwd();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    @(negedge clk);
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
